// File: rtl/patt_pkg.sv
// rtl/patt_pkg.sv - shared state encoding and default frame constants for the pattern link
package patt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } patt_state_e;

    localparam int PATT_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam logic [PATT_W_DEF-1:0] PATTERN_DEF = 4'b1010;

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/patt_detection.sv
// rtl/patt_detection.sv - sliding-window sync detector on the bit/enable serial interface
module patt_detection
    import patt_pkg::*;
#(
    parameter int                PATT_W  = PATT_W_DEF,
    parameter logic [PATT_W-1:0] PATTERN = PATTERN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    input  logic input_en,
    output logic match
);

    localparam int FILL_W = cnt_width(PATT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATT_W);
    localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(PATT_W - 1);

    logic [PATT_W-1:0] win_q;
    logic [PATT_W-1:0] win_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              match_q;
    logic              match_d;

    // A match is only reported once the window holds PATT_W real bits.
    always_comb begin
        win_d   = win_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (input_en) begin
            win_d   = (win_q << 1) | PATT_W'(data_in);
            match_d = (win_d == PATTERN) && (fill_q >= FILL_NEED);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/patt_piso.sv
// rtl/patt_piso.sv - parallel-load, shift-left register feeding the serial transmitter
module patt_piso #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift_en) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/patt_generator.sv
// rtl/patt_generator.sv - serial frame transmitter: sync pattern, payload, then idle gap
module patt_generator
    import patt_pkg::*;
#(
    parameter int                PATT_W  = PATT_W_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [PATT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int                GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] payload,
    input  logic              hold,
    output logic              data_out,
    output logic              out_en,
    output logic              busy,
    output logic              done
);

    localparam int FRAME_W = PATT_W + DATA_W;
    localparam int BCNT_W  = $clog2(FRAME_W + 1);
    localparam int GCNT_W  = cnt_width(GAP_CYC);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(FRAME_W);
    localparam logic [BCNT_W-1:0] BCNT_SYNC = BCNT_W'(PATT_W);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    patt_state_e       state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic              data_out_q, data_out_d;
    logic              out_en_q, out_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [FRAME_W-1:0] frame;
    logic               piso_load;
    logic               piso_shift;
    logic               piso_msb;

    assign frame = {PATTERN, payload};

    // The first frame bit goes straight to data_out on the accepting edge, so the
    // shift register is loaded with the remaining bits and bcnt counts bits sent.
    patt_piso #(
        .W(FRAME_W)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (piso_load),
        .shift_en (piso_shift),
        .d        ({frame[FRAME_W-2:0], 1'b0}),
        .msb      (piso_msb)
    );

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        gcnt_d     = gcnt_q;
        data_out_d = data_out_q;
        out_en_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                data_out_d = 1'b0;
                busy_d     = 1'b0;
                if (start) begin
                    piso_load  = 1'b1;
                    data_out_d = frame[FRAME_W-1];
                    out_en_d   = 1'b1;
                    busy_d     = 1'b1;
                    bcnt_d     = BCNT_W'(1);
                    state_d    = ST_SYNC;
                end
            end
            ST_SYNC, ST_DATA: begin
                // Frame completion does not wait on hold: done follows the last bit directly.
                if (bcnt_q == BCNT_LAST) begin
                    data_out_d = 1'b0;
                    done_d     = 1'b1;
                    bcnt_d     = '0;
                    gcnt_d     = '0;
                    if (GAP_CYC > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (!hold) begin
                    piso_shift = 1'b1;
                    data_out_d = piso_msb;
                    out_en_d   = 1'b1;
                    bcnt_d     = bcnt_q + 1'b1;
                    if (bcnt_q >= BCNT_SYNC) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_GAP: begin
                data_out_d = 1'b0;
                if (gcnt_q == GCNT_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bcnt_q     <= '0;
            gcnt_q     <= '0;
            data_out_q <= 1'b0;
            out_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            gcnt_q     <= gcnt_d;
            data_out_q <= data_out_d;
            out_en_q   <= out_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign out_en   = out_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_patt_generator.sv
// tb/tb_patt_generator.sv - directed self-checking bench for patt_generator looped into patt_detection
module tb_patt_generator;
    import patt_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] payload;
    logic       hold;
    logic       data_out;
    logic       out_en;
    logic       busy;
    logic       done;
    logic       match;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    patt_generator dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .payload  (payload),
        .hold     (hold),
        .data_out (data_out),
        .out_en   (out_en),
        .busy     (busy),
        .done     (done)
    );

    patt_detection det (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_out),
        .input_en (out_en),
        .match    (match)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame in the current cycle and follows it to the first idle cycle.
    task automatic run_frame(input logic [7:0] pl, input logic [11:0] exp_bits,
                             input int hold_at, input int hold_len, input int ign_at,
                             input bit keep_start, input string nm);
        int   bitn      = 0;
        int   hold_rem  = 0;
        int   guard     = 0;
        int   cyc;
        logic last_bit  = 1'b0;
        bit   match_due = 1'b0;
        payload = pl;
        start   = 1'b1;
        step();
        cyc = 1;
        if (!keep_start) start = 1'b0;
        while (bitn < 12 && guard < 40) begin
            guard++;
            if (match_due) begin
                check_eq({nm, "_match"}, match, 1);
                match_due = 1'b0;
            end
            check_eq({nm, "_busy"}, busy, 1);
            if (hold_rem > 0) begin
                check_eq({nm, "_held_en"}, out_en, 0);
                check_eq({nm, "_held_bit"}, data_out, last_bit);
                hold_rem--;
                if (hold_rem == 0) hold = 1'b0;
            end else begin
                check_eq({nm, "_en"}, out_en, 1);
                check_eq({nm, "_bit"}, data_out, exp_bits[11-bitn]);
                last_bit = exp_bits[11-bitn];
                bitn++;
                if (bitn == 4) match_due = 1'b1;
                if (bitn == hold_at && hold_len > 0) begin
                    hold     = 1'b1;
                    hold_rem = hold_len;
                end
            end
            if (cyc == ign_at) begin
                start   = 1'b1;
                payload = 8'hFF;
            end else if (cyc == ign_at + 1) begin
                start   = keep_start;
                payload = pl;
            end
            step();
            cyc++;
        end
        check_eq({nm, "_bitcount"}, bitn, 12);
        check_eq({nm, "_done"}, done, 1);
        check_eq({nm, "_done_en"}, out_en, 0);
        check_eq({nm, "_done_busy"}, busy, 1);
        check_eq({nm, "_done_do"}, data_out, 0);
        step();
        check_eq({nm, "_gap_done"}, done, 0);
        check_eq({nm, "_gap_busy"}, busy, 1);
        check_eq({nm, "_gap_en"}, out_en, 0);
        step();
        check_eq({nm, "_idle_busy"}, busy, 0);
        check_eq({nm, "_idle_en"}, out_en, 0);
        check_eq({nm, "_idle_done"}, done, 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b1;
        payload = 8'hC3;
        hold    = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_data_out", data_out, 0);
            check_eq("rst_out_en", out_en, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_en", out_en, 0);

        run_frame(8'hC3, 12'b1010_1100_0011, 0, 0, 0, 1'b0, "single");
        run_frame(8'hC3, 12'b1010_1100_0011, 6, 3, 0, 1'b0, "hold");
        run_frame(8'hC3, 12'b1010_1100_0011, 0, 0, 5, 1'b0, "ignstart");
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("no_second_busy", busy, 0);
            check_eq("no_second_en", out_en, 0);
        end

        run_frame(8'hA5, 12'b1010_1010_0101, 0, 0, 0, 1'b1, "b2b_a");
        run_frame(8'h5A, 12'b1010_0101_1010, 0, 0, 0, 1'b0, "b2b_b");

        payload = 8'hC3;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_eq("mid_bit7_en", out_en, 1);
        check_eq("mid_bit7", data_out, 0);
        rst = 1'b1;
        step();
        check_eq("mid_rst_en", out_en, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_do", data_out, 0);
        rst = 1'b0;
        step();
        check_eq("mid_after_done", done, 0);
        check_eq("mid_after_busy", busy, 0);
        check_eq("mid_after_en", out_en, 0);
        run_frame(8'h3C, 12'b1010_0011_1100, 0, 0, 0, 1'b0, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
